// File: rtl/xs_rom_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xs_rom_pkg
// Purpose  : Shared types, default widths and address mapping for the tile
//            ROM responder.
// Revision : 1.0 - initial release
// ============================================================================
package xs_rom_pkg;

  localparam int DEF_ADDR_WIDTH     = 14;
  localparam int DEF_DATA_WIDTH     = 16;
  localparam int DEF_SDR_ADDR_WIDTH = 24;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } rom_rsp_state_t;

  // Caller truncates to its SDRAM address width, giving modulo wrap.
  function automatic logic [31:0] map_addr(input logic [31:0] base,
                                           input logic [31:0] addr);
    return base + addr;
  endfunction

endpackage : xs_rom_pkg
`default_nettype wire

// File: rtl/xs_rom_pend_slot.sv
`default_nettype none
// ============================================================================
// Module   : xs_rom_pend_slot
// Purpose  : Depth-1, latest-wins pending request register with an
//            equality compare against the in-flight address.
// Revision : 1.0 - initial release
// ============================================================================
module xs_rom_pend_slot #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set,
  input  logic [ADDR_WIDTH-1:0] set_addr,
  input  logic                  clr,
  input  logic [ADDR_WIDTH-1:0] cmp_addr,
  output logic                  pend,
  output logic [ADDR_WIDTH-1:0] pend_addr,
  output logic                  match
);

  logic                  pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  always_comb begin
    pend_d = pend_q;
    addr_d = addr_q;
    if (set) begin
      pend_d = 1'b1;
      addr_d = set_addr;
    end
    if (clr) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      addr_q <= '0;
    end else begin
      pend_q <= pend_d;
      addr_q <= addr_d;
    end
  end

  // A strobe in the current cycle is visible as already pending.
  assign pend      = pend_q | set;
  assign pend_addr = set ? set_addr : addr_q;
  assign match     = (pend_addr == cmp_addr);

endmodule : xs_rom_pend_slot
`default_nettype wire

// File: rtl/xs_rom_responder.sv
`default_nettype none
// ============================================================================
// Module   : xs_rom_responder
// Purpose  : Turns tile ROM request strobes into SDRAM reads and returns the
//            latest completed word.
// Revision : 1.0 - initial release
// ============================================================================
module xs_rom_responder
  import xs_rom_pkg::*;
#(
  parameter int                      ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int                      DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int                      SDR_ADDR_WIDTH = DEF_SDR_ADDR_WIDTH,
  parameter logic [SDR_ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int                      TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                      clk,
  input  logic                      RSTn,
  input  logic                      ROM_req,
  input  logic [ADDR_WIDTH-1:0]     req_ROM_addr,
  output logic [DATA_WIDTH-1:0]     ROM_data,
  output logic                      ROM_valid,
  output logic                      sdr_req,
  output logic [SDR_ADDR_WIDTH-1:0] sdr_addr,
  input  logic                      sdr_ack,
  input  logic                      sdr_rdy,
  input  logic [DATA_WIDTH-1:0]     sdr_data,
  output logic                      busy,
  output logic                      err_timeout
);

  localparam int c_tcnt_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_tcnt_w-1:0] c_tcnt_max = c_tcnt_w'(TIMEOUT_CYCLES - 1);

  rom_rsp_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0]     rom_data_q, rom_data_d;
  logic                      rom_valid_q, rom_valid_d;
  logic                      sdr_req_q, sdr_req_d;
  logic [SDR_ADDR_WIDTH-1:0] sdr_addr_q, sdr_addr_d;
  logic                      busy_q, busy_d;
  logic                      err_q, err_d;
  logic [ADDR_WIDTH-1:0]     inflight_q, inflight_d;
  logic [c_tcnt_w-1:0]       tcnt_q, tcnt_d;

  logic                      pend_set, pend_clr, pend, pend_match;
  logic [ADDR_WIDTH-1:0]     pend_addr, issue_addr;
  logic [SDR_ADDR_WIDTH-1:0] mapped_addr;

  assign pend_set    = ROM_req && (state_q != IDLE);
  assign issue_addr  = ROM_req ? req_ROM_addr : pend_addr;
  assign mapped_addr = SDR_ADDR_WIDTH'(map_addr(32'(BASE_ADDR), 32'(issue_addr)));

  xs_rom_pend_slot #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_pend (
    .clk       (clk),
    .rst_n     (RSTn),
    .set       (pend_set),
    .set_addr  (req_ROM_addr),
    .clr       (pend_clr),
    .cmp_addr  (inflight_q),
    .pend      (pend),
    .pend_addr (pend_addr),
    .match     (pend_match)
  );

  always_comb begin
    state_d     = state_q;
    rom_data_d  = rom_data_q;
    rom_valid_d = 1'b0;
    sdr_req_d   = sdr_req_q;
    sdr_addr_d  = sdr_addr_q;
    err_d       = err_q;
    inflight_d  = inflight_q;
    tcnt_d      = tcnt_q;
    pend_clr    = 1'b0;

    case (state_q)
      IDLE: begin
        // A fresh strobe supersedes whatever was parked in the slot.
        if (ROM_req || pend) begin
          state_d    = ISSUE;
          inflight_d = issue_addr;
          sdr_addr_d = mapped_addr;
          sdr_req_d  = 1'b1;
          pend_clr   = 1'b1;
        end
      end
      ISSUE: begin
        if (sdr_ack) begin
          sdr_req_d = 1'b0;
          tcnt_d    = '0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        tcnt_d = tcnt_q + 1'b1;
        if (sdr_rdy) begin
          state_d = IDLE;
          // Data for a superseded address is dropped; the slot re-issues.
          if (!pend || pend_match) begin
            rom_data_d  = sdr_data;
            rom_valid_d = 1'b1;
            pend_clr    = pend;
          end
        end else if (tcnt_q == c_tcnt_max) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        sdr_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= IDLE;
      rom_data_q  <= '0;
      rom_valid_q <= 1'b0;
      sdr_req_q   <= 1'b0;
      sdr_addr_q  <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      inflight_q  <= '0;
      tcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      rom_data_q  <= rom_data_d;
      rom_valid_q <= rom_valid_d;
      sdr_req_q   <= sdr_req_d;
      sdr_addr_q  <= sdr_addr_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      inflight_q  <= inflight_d;
      tcnt_q      <= tcnt_d;
    end
  end

  assign ROM_data    = rom_data_q;
  assign ROM_valid   = rom_valid_q;
  assign sdr_req     = sdr_req_q;
  assign sdr_addr    = sdr_addr_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;

endmodule : xs_rom_responder
`default_nettype wire

// File: tb/tb_xs_rom_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_xs_rom_responder
// Purpose  : Directed vector bench for the tile ROM responder, plus a wrapped
//            base-address instance sharing the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xs_rom_responder;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rom_req = 1'b0;
  logic [13:0] req_addr = '0;
  logic        sdr_ack = 1'b0;
  logic        sdr_rdy = 1'b0;
  logic [15:0] sdr_data = '0;

  logic [15:0] rom_data, w_rom_data;
  logic        rom_valid, w_rom_valid;
  logic        sdr_req, w_sdr_req;
  logic [23:0] sdr_addr, w_sdr_addr;
  logic        busy, w_busy;
  logic        err_to, w_err_to;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  xs_rom_responder #(
    .ADDR_WIDTH(14), .DATA_WIDTH(16), .SDR_ADDR_WIDTH(24),
    .BASE_ADDR(24'h010000), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .RSTn(rstn), .ROM_req(rom_req), .req_ROM_addr(req_addr),
    .ROM_data(rom_data), .ROM_valid(rom_valid), .sdr_req(sdr_req),
    .sdr_addr(sdr_addr), .sdr_ack(sdr_ack), .sdr_rdy(sdr_rdy),
    .sdr_data(sdr_data), .busy(busy), .err_timeout(err_to)
  );

  xs_rom_responder #(
    .ADDR_WIDTH(14), .DATA_WIDTH(16), .SDR_ADDR_WIDTH(24),
    .BASE_ADDR(24'hFFFFF0), .TIMEOUT_CYCLES(64)
  ) dut_w (
    .clk(clk), .RSTn(rstn), .ROM_req(rom_req), .req_ROM_addr(req_addr),
    .ROM_data(w_rom_data), .ROM_valid(w_rom_valid), .sdr_req(w_sdr_req),
    .sdr_addr(w_sdr_addr), .sdr_ack(sdr_ack), .sdr_rdy(sdr_rdy),
    .sdr_data(sdr_data), .busy(w_busy), .err_timeout(w_err_to)
  );

  typedef struct {
    logic        req;
    logic [13:0] addr;
    logic        ack;
    logic        rdy;
    logic [15:0] data;
    logic [15:0] e_data;
    logic        e_valid;
    logic        e_sreq;
    logic [23:0] e_saddr;
    logic [23:0] e_waddr;
    logic        e_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic req, logic [13:0] addr, logic ack, logic rdy,
                              logic [15:0] data, logic [15:0] e_data, logic e_valid,
                              logic e_sreq, logic [23:0] e_saddr, logic [23:0] e_waddr,
                              logic e_busy);
    vec_t v;
    v.req = req; v.addr = addr; v.ack = ack; v.rdy = rdy; v.data = data;
    v.e_data = e_data; v.e_valid = e_valid; v.e_sreq = e_sreq;
    v.e_saddr = e_saddr; v.e_waddr = e_waddr; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic step(input logic req, input logic [13:0] addr, input logic ack,
                      input logic rdy, input logic [15:0] data);
    @(negedge clk);
    rom_req = req; req_addr = addr; sdr_ack = ack; sdr_rdy = rdy; sdr_data = data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // single request
    tbl.push_back(mk(1, 14'h0123, 0, 0, 16'h0,    16'h0000, 0, 1, 24'h010123, 24'h000113, 1));
    tbl.push_back(mk(0, 14'h0,    1, 0, 16'h0,    16'h0000, 0, 0, 24'h010123, 24'h000113, 1));
    tbl.push_back(mk(0, 14'h0,    0, 0, 16'h0,    16'h0000, 0, 0, 24'h010123, 24'h000113, 1));
    tbl.push_back(mk(0, 14'h0,    0, 0, 16'h0,    16'h0000, 0, 0, 24'h010123, 24'h000113, 1));
    tbl.push_back(mk(0, 14'h0,    0, 1, 16'hBEEF, 16'hBEEF, 1, 0, 24'h010123, 24'h000113, 0));
    tbl.push_back(mk(0, 14'h0,    0, 0, 16'h0,    16'hBEEF, 0, 0, 24'h010123, 24'h000113, 0));
    // supersede during WAIT; also wrap on the FFFFF0 instance
    tbl.push_back(mk(1, 14'h0010, 0, 0, 16'h0,    16'hBEEF, 0, 1, 24'h010010, 24'h000000, 1));
    tbl.push_back(mk(0, 14'h0,    1, 0, 16'h0,    16'hBEEF, 0, 0, 24'h010010, 24'h000000, 1));
    tbl.push_back(mk(1, 14'h0020, 0, 0, 16'h0,    16'hBEEF, 0, 0, 24'h010010, 24'h000000, 1));
    tbl.push_back(mk(0, 14'h0,    0, 1, 16'h1111, 16'hBEEF, 0, 0, 24'h010010, 24'h000000, 0));
    tbl.push_back(mk(0, 14'h0,    0, 0, 16'h0,    16'hBEEF, 0, 1, 24'h010020, 24'h000010, 1));
    tbl.push_back(mk(0, 14'h0,    1, 0, 16'h0,    16'hBEEF, 0, 0, 24'h010020, 24'h000010, 1));
    tbl.push_back(mk(0, 14'h0,    0, 1, 16'h2222, 16'h2222, 1, 0, 24'h010020, 24'h000010, 0));
    tbl.push_back(mk(0, 14'h0,    0, 0, 16'h0,    16'h2222, 0, 0, 24'h010020, 24'h000010, 0));
    // latest pending strobe equals in-flight address: single read, delivered
    tbl.push_back(mk(1, 14'h0005, 0, 0, 16'h0,    16'h2222, 0, 1, 24'h010005, 24'hFFFFF5, 1));
    tbl.push_back(mk(0, 14'h0,    1, 0, 16'h0,    16'h2222, 0, 0, 24'h010005, 24'hFFFFF5, 1));
    tbl.push_back(mk(1, 14'h0006, 0, 0, 16'h0,    16'h2222, 0, 0, 24'h010005, 24'hFFFFF5, 1));
    tbl.push_back(mk(1, 14'h0005, 0, 0, 16'h0,    16'h2222, 0, 0, 24'h010005, 24'hFFFFF5, 1));
    tbl.push_back(mk(0, 14'h0,    0, 1, 16'h3333, 16'h3333, 1, 0, 24'h010005, 24'hFFFFF5, 0));
    tbl.push_back(mk(0, 14'h0,    0, 0, 16'h0,    16'h3333, 0, 0, 24'h010005, 24'hFFFFF5, 0));
    tbl.push_back(mk(0, 14'h0,    0, 0, 16'h0,    16'h3333, 0, 0, 24'h010005, 24'hFFFFF5, 0));
    // rdy ignored in ISSUE; strobe coincident with rdy discards the old data
    tbl.push_back(mk(1, 14'h0007, 0, 0, 16'h0,    16'h3333, 0, 1, 24'h010007, 24'hFFFFF7, 1));
    tbl.push_back(mk(0, 14'h0,    0, 1, 16'hDEAD, 16'h3333, 0, 1, 24'h010007, 24'hFFFFF7, 1));
    tbl.push_back(mk(0, 14'h0,    1, 0, 16'h0,    16'h3333, 0, 0, 24'h010007, 24'hFFFFF7, 1));
    tbl.push_back(mk(1, 14'h0008, 0, 1, 16'h4444, 16'h3333, 0, 0, 24'h010007, 24'hFFFFF7, 0));
    tbl.push_back(mk(0, 14'h0,    0, 0, 16'h0,    16'h3333, 0, 1, 24'h010008, 24'hFFFFF8, 1));
    tbl.push_back(mk(0, 14'h0,    1, 0, 16'h0,    16'h3333, 0, 0, 24'h010008, 24'hFFFFF8, 1));
    tbl.push_back(mk(0, 14'h0,    0, 1, 16'h5555, 16'h5555, 1, 0, 24'h010008, 24'hFFFFF8, 0));

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst ROM_data", 32'(rom_data), 32'h0);
    check("rst ROM_valid", 32'(rom_valid), 32'h0);
    check("rst sdr_req", 32'(sdr_req), 32'h0);
    check("rst sdr_addr", 32'(sdr_addr), 32'h0);
    check("rst busy", 32'(busy), 32'h0);
    check("rst err_timeout", 32'(err_to), 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].req, tbl[i].addr, tbl[i].ack, tbl[i].rdy, tbl[i].data);
      check($sformatf("v%0d ROM_data", i),  32'(rom_data),   32'(tbl[i].e_data));
      check($sformatf("v%0d ROM_valid", i), 32'(rom_valid),  32'(tbl[i].e_valid));
      check($sformatf("v%0d sdr_req", i),   32'(sdr_req),    32'(tbl[i].e_sreq));
      check($sformatf("v%0d sdr_addr", i),  32'(sdr_addr),   32'(tbl[i].e_saddr));
      check($sformatf("v%0d wrap_addr", i), 32'(w_sdr_addr), 32'(tbl[i].e_waddr));
      check($sformatf("v%0d busy", i),      32'(busy),       32'(tbl[i].e_busy));
      check($sformatf("v%0d err", i),       32'(err_to),     32'h0);
    end

    // timeout: WAIT entered at the ack edge, abandoned on the 64th edge after it
    step(1, 14'h0100, 0, 0, 16'h0);
    check("to sdr_addr", 32'(sdr_addr), 32'h010100);
    step(0, 14'h0, 1, 0, 16'h0);
    for (int k = 0; k < 63; k++) step(0, 14'h0, 0, 0, 16'h0);
    check("to busy before", 32'(busy), 32'h1);
    check("to err before", 32'(err_to), 32'h0);
    step(0, 14'h0, 0, 0, 16'h0);
    check("to err after", 32'(err_to), 32'h1);
    check("to busy after", 32'(busy), 32'h0);
    check("to ROM_data kept", 32'(rom_data), 32'h5555);
    check("to no valid", 32'(rom_valid), 32'h0);

    // service resumes after a timeout; the flag stays sticky
    step(1, 14'h0200, 0, 0, 16'h0);
    check("post-to sdr_req", 32'(sdr_req), 32'h1);
    check("post-to sdr_addr", 32'(sdr_addr), 32'h010200);
    step(0, 14'h0, 1, 0, 16'h0);
    step(0, 14'h0, 0, 1, 16'h6666);
    check("post-to ROM_data", 32'(rom_data), 32'h6666);
    check("post-to ROM_valid", 32'(rom_valid), 32'h1);
    check("post-to err sticky", 32'(err_to), 32'h1);

    // asynchronous reset in WAIT with a request parked in the slot
    step(1, 14'h0300, 0, 0, 16'h0);
    step(0, 14'h0, 1, 0, 16'h0);
    step(1, 14'h0301, 0, 0, 16'h0);
    check("pre-rst busy", 32'(busy), 32'h1);
    #2;
    rom_req = 1'b0;
    rstn = 1'b0;
    #1;
    check("arst ROM_data", 32'(rom_data), 32'h0);
    check("arst ROM_valid", 32'(rom_valid), 32'h0);
    check("arst sdr_req", 32'(sdr_req), 32'h0);
    check("arst sdr_addr", 32'(sdr_addr), 32'h0);
    check("arst busy", 32'(busy), 32'h0);
    check("arst err_timeout", 32'(err_to), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    step(0, 14'h0, 0, 1, 16'h7777);
    check("late rdy no valid", 32'(rom_valid), 32'h0);
    check("late rdy data", 32'(rom_data), 32'h0);
    step(0, 14'h0, 0, 0, 16'h0);
    check("pend cleared sdr_req", 32'(sdr_req), 32'h0);
    check("pend cleared busy", 32'(busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_xs_rom_responder
`default_nettype wire
